stack_arbiter: RTL and testbench
================================

# stack_arbiter

Two-requester round-robin arbiter that shares one LIFO stack (stack controller plus register-file storage) between independent push/pop clients. It grants at most one operation per cycle and drives the stack's push/pop strobes and write data. It returns a registered response (pop data or error) to the granted requester one cycle later and maintains a shadow occupancy count. It sits between client logic and the stack storage/controller pair.

## Interface
- DATA_WIDTH, 8, stack word width
- ADDR_WIDTH, 4, stack address width; depth = 2**ADDR_WIDTH
- clk  input  1  clock, rising edge
- arst_n  input  1  reset, asynchronous, active-low
- req_valid  input  2  per-requester request valid (bit i = requester i)
- req_op  input  2  per-requester op: 0 = push, 1 = pop
- req_wdata  input  2*DATA_WIDTH  push data; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  output  2  one-hot grant; request i is accepted in the cycle where req_valid[i] and req_ready[i] are both 1
- rsp_valid  output  2  one-hot registered response strobe
- rsp_data  output  DATA_WIDTH  popped word; 0 for push responses and for errors
- rsp_err  output  1  1 = push while full, or pop while empty
- stk_push  output  1  push strobe to the stack controller
- stk_pop  output  1  pop strobe to the stack controller
- stk_wdata  output  DATA_WIDTH  write data to storage; valid when stk_push = 1
- stk_full  input  1  stack full flag
- stk_empty  input  1  stack empty flag
- stk_rdata  input  DATA_WIDTH  top-of-stack word, combinationally valid whenever stk_empty = 0
- level  output  ADDR_WIDTH+1  shadow occupancy, range 0..2**ADDR_WIDTH

## Operation
- Priority pointer `prio` (1 bit) selects the favoured requester. Reset value: 0.
- Grant selection, computed combinationally each cycle:
  - Both requesters valid: grant requester `prio`.
  - One requester valid: grant it.
  - None valid: no grant.
- After any grant to requester g: `prio` <= ~g. With no grant, `prio` holds.
- Requesters hold req_valid, req_op and req_wdata stable until accepted. Only the granted requester's fields are used.
- Granted push:
  - stk_full = 0: stk_push = 1, stk_wdata = the granted requester's data, response err = 0, data = 0.
  - stk_full = 1: stk_push = 0, response err = 1, data = 0.
- Granted pop:
  - stk_empty = 0: stk_pop = 1, response data = stk_rdata sampled in the grant cycle, err = 0.
  - stk_empty = 1: stk_pop = 0, response err = 1, data = 0.
- An error still consumes the grant and advances `prio`.
- stk_push and stk_pop are never both 1.
- level: +1 on stk_push, -1 on stk_pop. It never wraps: stk_full/stk_empty gating guarantees this.
- While arst_n = 0, req_ready, stk_push and stk_pop are forced to 0.

## Timing
- Reset values: rsp_valid = 0, rsp_data = 0, rsp_err = 0, level = 0, prio = 0. req_ready, stk_push and stk_pop are 0 during reset.
- req_ready, stk_push, stk_pop and stk_wdata are combinational in the grant cycle N. The stack updates at the end of cycle N.
- Response in cycle N+1: rsp_valid[g] = 1 for exactly one cycle, with rsp_data and rsp_err valid in the same cycle.
- rsp_data and rsp_err hold their values when rsp_valid = 0.
- Throughput: one operation per cycle, sustained. Back-to-back grants alternate between requesters when both are valid.
- Pop-after-push: a push granted in cycle N followed by a pop granted in cycle N+1 returns the pushed word, because the stack flags and top reflect the push in cycle N+1.
- Reset asserted mid-operation: any pending response is dropped (rsp_valid = 0 immediately), level = 0, prio = 0. The external stack must be reset by the same arst_n.

## Test plan
- Reset, then requester 0 pushes 0xA1 in cycle 1 -> req_ready = 01 in cycle 1; stk_push = 1, stk_wdata = 0xA1; rsp_valid = 01, rsp_err = 0 in cycle 2; level = 1.
- Both requesters valid continuously (r0 pushes 0x10, r1 pushes 0x20) from reset -> grants 01, 10, 01, 10 on successive cycles; level increments each cycle.
- Push 0x11, 0x22, 0x33 via r0, then pop three times via r1 -> rsp_data = 0x33, 0x22, 0x11 in that order, rsp_err = 0; level returns to 0.
- Pop on an empty stack via r1 -> stk_pop = 0, rsp_valid = 10, rsp_err = 1, rsp_data = 0, level stays 0.
- Fill 16 entries (ADDR_WIDTH = 4), then push 0xFF -> stk_push = 0, rsp_err = 1, level = 16. A following pop returns the 16th word with rsp_err = 0 and level = 15.
- Assert arst_n low in the cycle after a pop grant -> rsp_valid drops to 0 immediately, level = 0. After release, both requesters valid -> first grant goes to r0.

Source files
------------

// File: rtl/stack_arbiter_if.sv
// Client and stack-side bus of the two-requester LIFO arbiter.
// The slave modport is the arbiter's view; master is the clients-plus-stack side.
interface stack_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [1:0]              req_valid;
  logic [1:0]              req_op;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [1:0]              req_ready;
  logic [1:0]              rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    rsp_err;
  logic                    stk_push;
  logic                    stk_pop;
  logic [DATA_WIDTH-1:0]   stk_wdata;
  logic                    stk_full;
  logic                    stk_empty;
  logic [DATA_WIDTH-1:0]   stk_rdata;
  logic [ADDR_WIDTH:0]     level;

  modport slave (
    input  req_valid, req_op, req_wdata, stk_full, stk_empty, stk_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, stk_push, stk_pop, stk_wdata, level
  );

  modport master (
    output req_valid, req_op, req_wdata, stk_full, stk_empty, stk_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, stk_push, stk_pop, stk_wdata, level
  );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one LIFO between two clients; grant/strobes combinational,
// response registered one cycle later. Ungranted requesters are held off via req_ready.
module stack_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic            clk,
  input  logic            arst_n,
  stack_arbiter_if.slave  bus
);

  logic                  r_prio;
  logic [1:0]            r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_err;
  logic [ADDR_WIDTH:0]   r_level;

  logic [1:0]            w_grant;
  logic                  w_gidx;
  logic                  w_any;
  logic                  w_op;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_err;

  // Grants are suppressed while reset is held so no strobe reaches the stack.
  always_comb begin
    w_grant = 2'b00;
    if (arst_n) begin
      if (bus.req_valid == 2'b11) begin
        w_grant = r_prio ? 2'b10 : 2'b01;
      end else begin
        w_grant = bus.req_valid;
      end
    end
  end

  assign w_gidx  = w_grant[1];
  assign w_any   = |w_grant;
  assign w_op    = w_gidx ? bus.req_op[1] : bus.req_op[0];
  assign w_wdata = w_gidx ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                          : bus.req_wdata[DATA_WIDTH-1:0];

  // Full/empty gating keeps the shadow level inside 0..depth.
  assign w_push = w_any & ~w_op & ~bus.stk_full;
  assign w_pop  = w_any &  w_op & ~bus.stk_empty;
  assign w_err  = w_any & (w_op ? bus.stk_empty : bus.stk_full);

  assign bus.req_ready = w_grant;
  assign bus.stk_push  = w_push;
  assign bus.stk_pop   = w_pop;
  assign bus.stk_wdata = w_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.level     = r_level;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_prio      <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_grant;
      if (w_any) begin
        r_prio     <= ~w_gidx;
        r_rsp_data <= w_pop ? bus.stk_rdata : '0;
        r_rsp_err  <= w_err;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_level <= '0;
    end else if (w_push) begin
      r_level <= r_level + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end else if (w_pop) begin
      r_level <= r_level - {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed plus randomized bench for stack_arbiter against a queue-based reference model.
module tb_stack_arbiter;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  stack_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  stack_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  // Storage side: a plain array stack reset by the same arst_n.
  logic [DW-1:0] mem [DEPTH];
  int sp;
  assign bus.stk_full  = (sp == DEPTH);
  assign bus.stk_empty = (sp == 0);
  assign bus.stk_rdata = (sp > 0) ? mem[sp-1] : '0;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sp <= 0;
    end else if (bus.stk_push && sp < DEPTH) begin
      mem[sp] <= bus.stk_wdata;
      sp <= sp + 1;
    end else if (bus.stk_pop && sp > 0) begin
      sp <= sp - 1;
    end
  end

  // Reference model state.
  logic [DW-1:0] mq[$];
  logic          m_prio;
  logic [DW-1:0] m_data;
  logic          m_err;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] op,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      output logic [1:0] gnt);
    logic [1:0]    eg;
    int            g;
    logic          eop;
    logic [DW-1:0] ed;
    logic          epush, epop, eerr;
    logic [DW-1:0] edata;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_wdata = {d1, d0};
    #1;
    eg = 2'b00; g = 0; eop = 1'b0; ed = '0;
    epush = 1'b0; epop = 1'b0; eerr = 1'b0; edata = '0;
    if (v == 2'b11) g = m_prio ? 1 : 0;
    else if (v == 2'b10) g = 1;
    if (v != 2'b00) begin
      eg  = (g == 1) ? 2'b10 : 2'b01;
      eop = op[g];
      ed  = (g == 1) ? d1 : d0;
      if (!eop) begin
        if (mq.size() == DEPTH) eerr = 1'b1;
        else epush = 1'b1;
      end else begin
        if (mq.size() == 0) eerr = 1'b1;
        else begin
          epop  = 1'b1;
          edata = mq[$];
        end
      end
    end
    chk("req_ready", 32'(bus.req_ready), 32'(eg));
    chk("stk_push", 32'(bus.stk_push), 32'(epush));
    chk("stk_pop", 32'(bus.stk_pop), 32'(epop));
    if (epush) chk("stk_wdata", 32'(bus.stk_wdata), 32'(ed));
    @(posedge clk);
    #1;
    if (v != 2'b00) begin
      if (epush) mq.push_back(ed);
      if (epop) void'(mq.pop_back());
      m_prio = (g == 0);
      m_data = edata;
      m_err  = eerr;
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(eg));
    chk("rsp_data", 32'(bus.rsp_data), 32'(m_data));
    chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
    chk("level", 32'(bus.level), mq.size());
    gnt = eg;
  endtask

  task automatic push1(input int r, input logic [DW-1:0] d);
    logic [1:0] g;
    if (r == 0) step(2'b01, 2'b00, d, 8'h00, g);
    else        step(2'b10, 2'b00, 8'h00, d, g);
  endtask

  task automatic pop1(input int r);
    logic [1:0] g;
    if (r == 0) step(2'b01, 2'b11, 8'h00, 8'h00, g);
    else        step(2'b10, 2'b11, 8'h00, 8'h00, g);
  endtask

  logic [1:0]    g;
  logic [1:0]    pv, po;
  logic [DW-1:0] pd0, pd1;

  initial begin
    m_prio = 1'b0; m_data = '0; m_err = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_op    = 2'b00;
    bus.req_wdata = {8'h20, 8'h10};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_stk_push", 32'(bus.stk_push), 0);
    chk("rst_stk_pop", 32'(bus.stk_pop), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_level", 32'(bus.level), 0);
    bus.req_valid = 2'b00;
    arst_n = 1'b1;

    push1(0, 8'hA1);
    pop1(1);
    for (int i = 0; i < 4; i++) step(2'b11, 2'b00, 8'h10, 8'h20, g);
    for (int i = 0; i < 4; i++) pop1(0);
    push1(0, 8'h11); push1(0, 8'h22); push1(0, 8'h33);
    for (int i = 0; i < 3; i++) pop1(1);
    pop1(1);
    for (int i = 0; i < DEPTH; i++) push1(0, 8'(i + 8'h40));
    push1(0, 8'hFF);
    pop1(1);

    // Reset arrives the cycle after a pop grant: response must vanish at once.
    pop1(1);
    @(negedge clk);
    arst_n = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("midrst_level", 32'(bus.level), 0);
    chk("midrst_req_ready", 32'(bus.req_ready), 0);
    chk("midrst_stk_pop", 32'(bus.stk_pop), 0);
    mq.delete();
    m_prio = 1'b0; m_data = '0; m_err = 1'b0;
    chk("midrst_rsp_data", 32'(bus.rsp_data), 0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    arst_n = 1'b1;
    step(2'b11, 2'b00, 8'h55, 8'h66, g);
    chk("post_rst_first_grant", 32'(g), 32'(2'b01));

    // Random traffic; requests stay asserted and unchanged until granted.
    pv = 2'b00; po = 2'b00; pd0 = '0; pd1 = '0;
    for (int n = 0; n < 400; n++) begin
      int thr;
      thr = (n % 100 < 50) ? 3 : 7;
      if (!pv[0] && $urandom_range(0, 3) != 0) begin
        pv[0] = 1'b1; po[0] = ($urandom_range(0, 9) < thr); pd0 = 8'($urandom);
      end
      if (!pv[1] && $urandom_range(0, 3) != 0) begin
        pv[1] = 1'b1; po[1] = ($urandom_range(0, 9) < thr); pd1 = 8'($urandom);
      end
      step(pv, po, pd0, pd1, g);
      pv = pv & ~g;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
